// File: rtl/radiant_aux_ctrl_if.sv
// Control-frame and monitor signal bundle for radiant_aux_ctrl.
// master drives the serial line and monitor inputs; slave is the controller.
interface radiant_aux_ctrl_if #(
  parameter int NCHAN = 12,
  parameter int SEL_W = 4
);
  logic             CTRL_DATA;
  logic [NCHAN-1:0] MONTIMING;
  logic             MON_OUT;
  logic [SEL_W-1:0] SEL;
  logic [2:0]       ASEL;
  logic             BIST;
  logic             SCAN;
  logic             FRAME_OK;
  logic             FRAME_ERR;
  logic [3:0]       LED;

  modport master (
    output CTRL_DATA, MONTIMING,
    input  MON_OUT, SEL, ASEL, BIST, SCAN, FRAME_OK, FRAME_ERR, LED
  );

  modport slave (
    input  CTRL_DATA, MONTIMING,
    output MON_OUT, SEL, ASEL, BIST, SCAN, FRAME_OK, FRAME_ERR, LED
  );
endinterface

// File: rtl/radiant_aux_ctrl.sv
// Framed serial control receiver and monitor/BIST select controller with auto-scan.
// Optional parity bit enabled by defining CTRL_PARITY_EN.
module radiant_aux_ctrl #(
  parameter int               NCHAN     = 12,
  parameter int               SEL_W     = 4,
  parameter logic [NCHAN-1:0] MT_INVERT = 12'b010011100001,
  parameter int               DWELL     = 1024,
  parameter int               DWELL_W   = 16
) (
  input  logic               CTRL_CLK,
  input  logic               CTRL_RST,
  radiant_aux_ctrl_if.slave  bus
);

  localparam int P     = SEL_W + 4;
  localparam int CNT_W = $clog2(P);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef CTRL_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(P - 1);
  localparam logic [SEL_W-1:0]   NCHAN_S    = SEL_W'(NCHAN);
  localparam logic [SEL_W-1:0]   LAST_CHAN  = SEL_W'(NCHAN - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [P-1:0]       shreg;
  logic [SEL_W-1:0]   sel_q;
  logic [2:0]         asel_q;
  logic               bist_q;
  logic               scan_q;
  logic               ok_q;
  logic               err_q;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [SEL_W-1:0]   f_sel;
  logic [2:0]         f_asel;
  logic               f_bist;
  logic               f_scan;
  logic               range_ok;
  logic               frame_good;
  logic               accept;
  logic               reject;

  assign f_sel    = shreg[SEL_W-1:0];
  assign f_asel   = shreg[SEL_W+2:SEL_W];
  assign f_bist   = shreg[SEL_W+3];
  assign f_scan   = (f_sel == '1);
  assign range_ok = (f_sel < NCHAN_S) || f_scan;

`ifdef CTRL_PARITY_EN
  logic par_ok;
  assign frame_good = ~bus.CTRL_DATA & par_ok & range_ok;
`else
  assign frame_good = ~bus.CTRL_DATA & range_ok;
`endif

  assign accept = (state == S_STOP) &&  frame_good;
  assign reject = (state == S_STOP) && !frame_good;

  // Frame receiver: the payload is only latched into the outputs at the stop edge.
  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef CTRL_PARITY_EN
      par_ok  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.CTRL_DATA) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          shreg <= {bus.CTRL_DATA, shreg[P-1:1]};
          if (bit_cnt == LAST_BIT) begin
`ifdef CTRL_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef CTRL_PARITY_EN
        S_PARITY: begin
          par_ok <= ^{bus.CTRL_DATA, shreg};
          state  <= S_STOP;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Select/scan state: an accepted frame always wins over a scan step on the same edge.
  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      sel_q     <= '0;
      asel_q    <= 3'b100;
      bist_q    <= 1'b0;
      scan_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      ok_q <= accept;
      if (accept) begin
        asel_q <= f_asel;
        bist_q <= f_bist;
        err_q  <= 1'b0;
        scan_q <= f_scan;
        if (f_scan) begin
          sel_q     <= '0;
          dwell_cnt <= '0;
        end else begin
          sel_q <= f_sel;
        end
      end else begin
        if (reject) err_q <= 1'b1;
        if (scan_q) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            sel_q     <= (sel_q == LAST_CHAN) ? '0 : sel_q + 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
      end
    end
  end

  logic [SEL_W+3:0] sel_ext;
  assign sel_ext = {4'b0000, sel_q};

  assign bus.SEL       = sel_q;
  assign bus.ASEL      = asel_q;
  assign bus.BIST      = bist_q;
  assign bus.SCAN      = scan_q;
  assign bus.FRAME_OK  = ok_q;
  assign bus.FRAME_ERR = err_q;
  assign bus.LED       = bist_q ? {1'b1, asel_q} : sel_ext[3:0];
  assign bus.MON_OUT   = bus.MONTIMING[sel_q] ^ MT_INVERT[sel_q];

endmodule

// File: tb/tb_radiant_aux_ctrl.sv
// Scoreboard bench for radiant_aux_ctrl: expected state is queued at each stop bit
// and compared one cycle later by a monitor; scan stepping and MON_OUT checked inline.
module tb_radiant_aux_ctrl;
  localparam int NCHAN = 12;
  localparam int SEL_W = 4;
  localparam int DWELL = 4;
  localparam logic [11:0] MT_INV = 12'b010011100001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radiant_aux_ctrl_if #(.NCHAN(NCHAN), .SEL_W(SEL_W)) bus ();

  radiant_aux_ctrl #(
    .NCHAN(NCHAN), .SEL_W(SEL_W), .MT_INVERT(MT_INV), .DWELL(DWELL), .DWELL_W(16)
  ) dut (
    .CTRL_CLK(clk),
    .CTRL_RST(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int sel; int asel; int bist; int scan; int err; int ok;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int total = 0;
  int bad = 0;
  int ok_seen = 0;
  int ok_exp = 0;
  logic [11:0] mt_inv_v = MT_INV;

  task automatic check(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic void push_exp(input int sel, input int asel, input int bist,
                                   input bit bad_par, input bit stop);
    bit acc;
    acc = !stop && (sel < NCHAN || sel == 15);
`ifdef CTRL_PARITY_EN
    acc = acc && !bad_par;
`else
    if (bad_par) acc = acc;
`endif
    if (acc) begin
      m.asel = asel; m.bist = bist; m.err = 0; m.ok = 1;
      if (sel == 15) begin m.sel = 0; m.scan = 1; end
      else begin m.sel = sel; m.scan = 0; end
      ok_exp++;
    end else begin
      m.err = 1; m.ok = 0;
    end
    q.push_back(m);
  endfunction

  task automatic send(input int sel, input int asel, input int bist,
                      input bit bad_par, input bit stop);
    logic [7:0]  pl;
    logic [11:0] bits;
    logic [3:0]  s4;
    logic [2:0]  a3;
    int n;
    s4 = sel[3:0]; a3 = asel[2:0];
    pl = {bist[0], a3, s4};
    bits = '0;
    bits[0] = 1'b1;
    for (int i = 0; i < 8; i++) bits[1+i] = pl[i];
    n = 9;
`ifdef CTRL_PARITY_EN
    bits[9] = ~(^pl) ^ bad_par;
    n = 10;
`endif
    bits[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) push_exp(sel, asel, bist, bad_par, stop);
      bus.CTRL_DATA = bits[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.CTRL_DATA = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (bus.FRAME_OK) ok_seen++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sel", int'(bus.SEL), e.sel);
      check("asel", int'(bus.ASEL), e.asel);
      check("bist", int'(bus.BIST), e.bist);
      check("scan", int'(bus.SCAN), e.scan);
      check("frame_err", int'(bus.FRAME_ERR), e.err);
      check("frame_ok", int'(bus.FRAME_OK), e.ok);
      check("led", int'(bus.LED), e.bist ? (8 | e.asel) : (e.sel & 15));
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_sel"}, int'(bus.SEL), 0);
    check({tag, "_asel"}, int'(bus.ASEL), 4);
    check({tag, "_bist"}, int'(bus.BIST), 0);
    check({tag, "_scan"}, int'(bus.SCAN), 0);
    check({tag, "_led"}, int'(bus.LED), 0);
    check({tag, "_ok"}, int'(bus.FRAME_OK), 0);
    check({tag, "_err"}, int'(bus.FRAME_ERR), 0);
  endtask

  initial begin
    logic [11:0] pats [5];
    logic [11:0] pat;
    int es;
    pats[0] = 12'h000; pats[1] = 12'hFFF; pats[2] = 12'h020;
    pats[3] = 12'hFDF; pats[4] = 12'hA5C;
    m = '{sel: 0, asel: 4, bist: 0, scan: 0, err: 0, ok: 0};
    bus.CTRL_DATA = 1'b0;
    bus.MONTIMING = '0;
    #22;
    check_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // valid frame and MON_OUT polarity on channel 5
    send(5, 2, 1, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      pat = pats[i];
      bus.MONTIMING = pat;
      #1;
      check("mon_out_ch5", int'(bus.MON_OUT), int'(pat[5] ^ mt_inv_v[5]));
    end

    // rejected frames leave selection alone and set FRAME_ERR
`ifdef CTRL_PARITY_EN
    send(6, 1, 0, 1'b1, 1'b0);
    idle(2);
`endif
    send(6, 1, 0, 1'b0, 1'b1);
    idle(2);
    send(12, 1, 0, 1'b0, 1'b0);
    idle(2);
    send(9, 3, 0, 1'b0, 1'b0);
    idle(2);

    // asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_async");
    m = '{sel: 0, asel: 4, bist: 0, scan: 0, err: 0, ok: 0};
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // partial frame (start + 4 payload bits) discarded by reset
    @(negedge clk); bus.CTRL_DATA = 1'b1;
    @(negedge clk); bus.CTRL_DATA = 1'b1;
    @(negedge clk); bus.CTRL_DATA = 1'b1;
    @(negedge clk); bus.CTRL_DATA = 1'b1;
    @(negedge clk); bus.CTRL_DATA = 1'b0;
    @(negedge clk); rst = 1'b1; bus.CTRL_DATA = 1'b0;
    @(negedge clk); rst = 1'b0;
    idle(2);
    send(7, 0, 0, 1'b0, 1'b0);
    idle(2);

    // back-to-back frames with no idle bits
    send(1, 0, 0, 1'b0, 1'b0);
    send(2, 5, 0, 1'b0, 1'b0);
    idle(3);

    // auto-scan: each channel held DWELL cycles, wraps 11 -> 0
    send(15, 1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 13 * DWELL; k++) begin
      @(posedge clk);
      #1;
      es = (k / DWELL) % NCHAN;
      check("scan_sel", int'(bus.SEL), es);
      check("scan_on", int'(bus.SCAN), 1);
      pat = 12'($urandom);
      bus.MONTIMING = pat;
      #1;
      check("scan_mon", int'(bus.MON_OUT), int'(pat[es] ^ mt_inv_v[es]));
    end
    send(3, 2, 1, 1'b0, 1'b0);
    idle(4);

    check("ok_pulses", ok_seen, ok_exp);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
